// File: rtl/iter_shift_ctrl_if.sv
// Request/response bundle for the iterative shifter: the requester drives the
// request fields, and the shifter answers with status and result.
`ifndef INST_ID_LEN
`define INST_ID_LEN 8
`endif
`ifndef NONE_ID
`define NONE_ID 8'h00
`endif
`ifndef SLLI_ID
`define SLLI_ID 8'h01
`endif
`ifndef SRLI_ID
`define SRLI_ID 8'h02
`endif
`ifndef SRAI_ID
`define SRAI_ID 8'h03
`endif

interface iter_shift_ctrl_if #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
);
  logic                    start;
  logic [`INST_ID_LEN-1:0] instr_id;
  logic [XLEN-1:0]         rs1_data;
  logic [SHAMT_W-1:0]      shamt;
  logic                    flush;
  logic                    ready;
  logic                    busy;
  logic                    done;
  logic [XLEN-1:0]         result;
  logic                    err;

  modport master (
    output start, instr_id, rs1_data, shamt, flush,
    input  ready, busy, done, result, err
  );

  modport slave (
    input  start, instr_id, rs1_data, shamt, flush,
    output ready, busy, done, result, err
  );
endinterface

// File: rtl/iter_shift_ctrl.sv
// Multi-cycle immediate shifter (SLLI/SRLI/SRAI): one bit position per cycle,
// so a shift by N takes N+1 cycles from accept to the done pulse.
`ifndef INST_ID_LEN
`define INST_ID_LEN 8
`endif
`ifndef NONE_ID
`define NONE_ID 8'h00
`endif
`ifndef SLLI_ID
`define SLLI_ID 8'h01
`endif
`ifndef SRLI_ID
`define SRLI_ID 8'h02
`endif
`ifndef SRAI_ID
`define SRAI_ID 8'h03
`endif

module iter_shift_ctrl #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input logic               clk,
  input logic               rst,
  iter_shift_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_SLL = 2'd0,
    OP_SRL = 2'd1,
    OP_SRA = 2'd2
  } op_t;

  state_t               r_state;
  state_t               w_state_nxt;
  op_t                  r_op;
  op_t                  w_op;
  logic [XLEN-1:0]      r_opnd;
  logic [XLEN-1:0]      r_result;
  logic [SHAMT_W-1:0]   r_count;
  logic                 r_err;
  logic                 w_supported;
  logic                 w_accept;
  logic                 w_last_step;
  logic [XLEN-1:0]      w_shifted;

  function automatic logic [XLEN-1:0] shift_one(input op_t op, input logic [XLEN-1:0] v);
    logic signed [XLEN-1:0] sv;
    sv = $signed(v);
    case (op)
      OP_SLL:  shift_one = {v[XLEN-2:0], 1'b0};
      OP_SRL:  shift_one = {1'b0, v[XLEN-1:1]};
      OP_SRA:  shift_one = $unsigned(sv >>> 1);
      default: shift_one = v;
    endcase
  endfunction

  always_comb begin
    w_op        = OP_SLL;
    w_supported = 1'b1;
    case (bus.instr_id)
      `SLLI_ID: w_op = OP_SLL;
      `SRLI_ID: w_op = OP_SRL;
      `SRAI_ID: w_op = OP_SRA;
      default:  w_supported = 1'b0;
    endcase
  end

  assign w_accept    = bus.start & (r_state == S_IDLE) & ~bus.flush;
  assign w_last_step = (r_count == SHAMT_W'(1));
  assign w_shifted   = shift_one(r_op, r_opnd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_supported || (bus.shamt == '0)) w_state_nxt = S_DONE;
          else                                   w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bus.flush)        w_state_nxt = S_IDLE;
        else if (w_last_step) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Working operand: loaded on accept, shifted one bit per SHIFT cycle
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_opnd <= bus.rs1_data;
      r_op   <= w_op;
    end else if (r_state == S_SHIFT) begin
      r_opnd <= w_shifted;
    end
  end

  // Result/err only change on entry to DONE, so result holds between ops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_count <= w_supported ? bus.shamt : '0;
            if (!w_supported || (bus.shamt == '0)) begin
              r_result <= w_supported ? bus.rs1_data : '0;
              r_err    <= ~w_supported;
            end
          end
        end
        S_SHIFT: begin
          if (bus.flush) begin
            r_count <= '0;
          end else begin
            r_count <= r_count - SHAMT_W'(1);
            if (w_last_step) begin
              r_result <= w_shifted;
              r_err    <= 1'b0;
            end
          end
        end
        default: r_count <= '0;
      endcase
    end
  end

  always_comb begin
    bus.ready  = (r_state == S_IDLE);
    bus.busy   = (r_state == S_SHIFT) || (r_state == S_DONE);
    bus.done   = (r_state == S_DONE);
    bus.err    = (r_state == S_DONE) && r_err;
    bus.result = r_result;
  end

endmodule

// File: tb/tb_iter_shift_ctrl.sv
// Directed bench for iter_shift_ctrl: latency, shift results, errors, flush,
// asynchronous reset and back-to-back issue.
module tb_iter_shift_ctrl;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  iter_shift_ctrl_if #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) bus ();

  iter_shift_ctrl #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Call at a negedge; returns just after the accepting posedge
  task automatic issue(input logic [7:0] id, input logic [31:0] rs1, input logic [4:0] sh);
    bus.start    = 1'b1;
    bus.instr_id = id;
    bus.rs1_data = rs1;
    bus.shamt    = sh;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Negedges counted from the accept edge until done; 0 on timeout
  task automatic wait_done(output int lat, output logic [31:0] res, output logic e);
    lat = 0;
    res = '0;
    e   = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i;
        res = bus.result;
        e   = bus.err;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] id, input logic [31:0] rs1,
                        input logic [4:0] sh, input int exp_lat, input logic [31:0] exp_res,
                        input logic exp_err);
    int          lat;
    logic [31:0] res;
    logic        e;
    issue(id, rs1, sh);
    wait_done(lat, res, e);
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_res"}, res, exp_res);
    check_eq({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done) n++;
    end
  endtask

  initial begin
    int          nd;
    int          lat;
    logic [31:0] res;
    logic        e;
    n_chk        = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.instr_id = `NONE_ID;
    bus.rs1_data = '0;
    bus.shamt    = '0;
    bus.flush    = 1'b0;

    #2;
    check_eq("rst_ready",  {31'd0, bus.ready}, 32'd1);
    check_eq("rst_busy",   {31'd0, bus.busy},  32'd0);
    check_eq("rst_done",   {31'd0, bus.done},  32'd0);
    check_eq("rst_err",    {31'd0, bus.err},   32'd0);
    check_eq("rst_result", bus.result,         32'd0);
    #21 rst = 1'b0;
    @(negedge clk);

    run_op("slli4", `SLLI_ID, 32'h0000_0001, 5'd4, 5, 32'h0000_0010, 1'b0);
    @(negedge clk);
    check_eq("slli4_pulse", {31'd0, bus.done}, 32'd0);
    check_eq("slli4_hold",  bus.result,        32'h0000_0010);
    check_eq("slli4_ready", {31'd0, bus.ready}, 32'd1);

    run_op("srai31", `SRAI_ID, 32'h8000_0000, 5'd31, 32, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    run_op("srli31", `SRLI_ID, 32'h8000_0000, 5'd31, 32, 32'h0000_0001, 1'b0);
    @(negedge clk);
    run_op("srai_pos", `SRAI_ID, 32'h4000_00F0, 5'd4, 5, 32'h0400_000F, 1'b0);
    @(negedge clk);
    run_op("srli0", `SRLI_ID, 32'h1234_5678, 5'd0, 1, 32'h1234_5678, 1'b0);
    @(negedge clk);

    // Asynchronous reset in the middle of a long SRAI
    issue(`SRAI_ID, 32'h8000_0000, 5'd20);
    repeat (5) @(negedge clk);
    check_eq("mid_busy", {31'd0, bus.busy}, 32'd1);
    #3 rst = 1'b1;
    #1;
    check_eq("arst_ready",  {31'd0, bus.ready}, 32'd1);
    check_eq("arst_busy",   {31'd0, bus.busy},  32'd0);
    check_eq("arst_done",   {31'd0, bus.done},  32'd0);
    check_eq("arst_err",    {31'd0, bus.err},   32'd0);
    check_eq("arst_result", bus.result,         32'd0);
    #4 rst = 1'b0;
    count_dones(25, nd);
    check_eq("arst_no_done", nd, 0);
    run_op("post_rst", `SLLI_ID, 32'h0000_0003, 5'd1, 2, 32'h0000_0006, 1'b0);
    @(negedge clk);

    run_op("none_id", `NONE_ID, 32'hDEAD_BEEF, 5'd7, 1, 32'h0000_0000, 1'b1);
    @(negedge clk);
    run_op("bad_id", 8'h7F, 32'h0000_00FF, 5'd0, 1, 32'h0000_0000, 1'b1);
    @(negedge clk);

    // Flush during SHIFT, with a stray start that must be ignored
    issue(`SLLI_ID, 32'h0000_0001, 5'd10);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.instr_id = `SRLI_ID;
    bus.rs1_data = 32'hFFFF_FFFF;
    bus.shamt    = 5'd2;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("fl_busy",  {31'd0, bus.busy},  32'd1);
    check_eq("fl_ready", {31'd0, bus.ready}, 32'd0);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check_eq("fl_idle_ready", {31'd0, bus.ready}, 32'd1);
    check_eq("fl_idle_busy",  {31'd0, bus.busy},  32'd0);
    check_eq("fl_idle_done",  {31'd0, bus.done},  32'd0);
    count_dones(20, nd);
    check_eq("fl_no_done", nd, 0);

    // Flush together with start in IDLE: no accept
    bus.flush    = 1'b1;
    bus.start    = 1'b1;
    bus.instr_id = `SLLI_ID;
    bus.shamt    = 5'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    check_eq("fl_start_ready", {31'd0, bus.ready}, 32'd1);
    check_eq("fl_start_done",  {31'd0, bus.done},  32'd0);

    // Back-to-back: second start held from the first done onward
    issue(`SLLI_ID, 32'h0000_0005, 5'd1);
    wait_done(lat, res, e);
    check_eq("b2b1_lat", lat, 2);
    check_eq("b2b1_res", res, 32'h0000_000A);
    bus.start    = 1'b1;
    bus.instr_id = `SRLI_ID;
    bus.rs1_data = 32'h8000_0000;
    bus.shamt    = 5'd1;
    @(negedge clk);
    check_eq("b2b_idle_ready", {31'd0, bus.ready}, 32'd1);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(lat, res, e);
    check_eq("b2b2_lat", lat, 2);
    check_eq("b2b2_res", res, 32'h4000_0000);
    check_eq("b2b2_err", {31'd0, e}, 32'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/iter_shift_ctrl.md
ITER_SHIFT_CTRL -- requirements
Module: iter_shift_ctrl

Interface
REQ-001 Parameter XLEN, default 32, operand/result width in bits.
REQ-002 Parameter SHAMT_W, default 5, shift-amount width; SHALL equal log2(XLEN).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request valid; qualified by ready.
REQ-006 instr_id  input  `INST_ID_LEN  operation code from the OP_IMM identifier (`SLLI_ID, `SRLI_ID, `SRAI_ID).
REQ-007 rs1_data  input  XLEN  operand to shift.
REQ-008 shamt  input  SHAMT_W  shift amount.
REQ-009 flush  input  1  abort the current operation (pipeline flush).
REQ-010 ready  output  1  high only in IDLE; start accepted when start & ready & !flush.
REQ-011 busy  output  1  high in SHIFT and DONE.
REQ-012 done  output  1  one-cycle pulse; result and err valid in the same cycle.
REQ-013 result  output  XLEN  shifted value.
REQ-014 err  output  1  high with done when instr_id is unsupported.

Function
REQ-015 FSM states: IDLE, SHIFT, DONE; encoded in a registered state variable.
REQ-016 IDLE -> SHIFT on accept with shamt != 0 and supported instr_id; operand, op and shamt latched into internal registers at accept.
REQ-017 IDLE -> DONE on accept with shamt == 0 or unsupported instr_id; operand latched unchanged.
REQ-018 SHIFT: each cycle shifts latched operand by exactly 1 bit and decrements remaining count by 1.
REQ-019 SLLI: shift left, zero fill LSB; SRLI: shift right, zero fill MSB; SRAI: shift right, replicate bit XLEN-1.
REQ-020 SHIFT -> DONE on the cycle the count reaches 0 (after shamt shift cycles).
REQ-021 DONE: done=1, result=latched register, err per REQ-022; DONE -> IDLE unconditionally next cycle.
REQ-022 Unsupported instr_id (any value other than the three IDs, incl. `NONE_ID): done after 1 cycle, err=1, result=0.
REQ-023 Latency: done asserted exactly shamt+1 cycles after the accept edge (1 cycle for shamt==0 or error); shamt=31 -> 32 cycles.
REQ-024 start while busy is ignored; no queueing; inputs other than at accept have no effect.
REQ-025 flush in SHIFT or DONE: next state IDLE, done not asserted in the following cycle, count cleared; if DONE and flush coincide, done still shows 1 in that DONE cycle but the consumer discards it.
REQ-026 flush with start in IDLE: start not accepted; state stays IDLE.
REQ-027 result holds its last value outside DONE; only done qualifies it.
REQ-028 Back-to-back: a new start is accepted in the IDLE cycle immediately following DONE; minimum issue interval shamt+2 cycles.

Reset
REQ-029 rst asserted: state=IDLE, ready=1, busy=0, done=0, err=0, result=0, count=0, immediately (asynchronous), regardless of clk.
REQ-030 rst mid-operation discards the operation; no done after release.
REQ-031 First accept possible on the first rising clk edge after rst deasserts.

Verification
REQ-032 SLLI rs1=0x0000_0001, shamt=4 -> done 5 cycles after accept, result=0x0000_0010, err=0.
REQ-033 SRAI rs1=0x8000_0000, shamt=31 -> done 32 cycles after accept, result=0xFFFF_FFFF; SRLI same operands -> result=0x0000_0001.
REQ-034 SRLI rs1=0x1234_5678, shamt=0 -> done 1 cycle after accept, result=0x1234_5678; instr_id=`NONE_ID -> done 1 cycle, err=1, result=0.
REQ-035 SLLI shamt=10, flush at cycle 3 after accept -> IDLE next cycle, no done within 20 cycles, ready=1; start during SHIFT ignored.
REQ-036 rst pulse (not clk-aligned) at cycle 5 of SRAI shamt=20 -> all outputs reset values immediately, no done afterwards; new SLLI rs1=0x3, shamt=1 after release -> result=0x6 after 2 cycles.
REQ-037 Back-to-back SLLI shamt=1 then SRLI shamt=1: second accept in cycle right after first done; both results correct.
